// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store unit in front of a word-wide d_mem. Handles
//            byte/half/word loads with extension and sub-word stores by RMW.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32   // lane logic assumes four byte lanes
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  uns,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_adr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RMW_RD = 2'd2,
    WRITE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Operation latched at accept
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata;

  logic                  r_done;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_mem_adr;
  logic [DATA_WIDTH-1:0] r_mem_din;
  logic                  r_mem_we;

  logic                  w_accept;
  logic                  w_illegal;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic                  w_sign_b;
  logic                  w_sign_h;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_merge_data;

  assign ready   = (r_state == IDLE) && rst_n;
  assign done    = r_done;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign mem_adr = r_mem_adr;
  assign mem_din = r_mem_din;
  assign mem_we  = r_mem_we;

  assign w_accept  = ready && req;
  assign w_illegal = (size == c_SIZE_ILL)
                   || ((size == c_SIZE_HALF) && addr[0])
                   || ((size == c_SIZE_WORD) && (addr[1:0] != 2'b00));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Illegal accesses never leave IDLE; the error pulse comes from the datapath.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_accept && !w_illegal) begin
          if (!we) begin
            w_state_next = LOAD;
          end else if (size == c_SIZE_WORD) begin
            w_state_next = WRITE;
          end else begin
            w_state_next = RMW_RD;
          end
        end
      end
      LOAD:    w_state_next = IDLE;
      RMW_RD:  w_state_next = WRITE;
      WRITE:   w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Lane extraction for loads and lane merge for sub-word stores
  // ---------------------------------------------------------------------------
  always_comb begin
    w_byte   = mem_dout[{r_lane, 3'b000} +: 8];
    w_half   = mem_dout[{r_lane[1], 4'b0000} +: 16];
    w_sign_b = ~r_uns & w_byte[7];
    w_sign_h = ~r_uns & w_half[15];
    unique case (r_size)
      c_SIZE_BYTE: w_load_data = {{(DATA_WIDTH-8){w_sign_b}}, w_byte};
      c_SIZE_HALF: w_load_data = {{(DATA_WIDTH-16){w_sign_h}}, w_half};
      default:     w_load_data = mem_dout;
    endcase
  end

  always_comb begin
    w_merge_data = mem_dout;
    if (r_size == c_SIZE_BYTE) begin
      w_merge_data[{r_lane, 3'b000} +: 8] = r_wdata[7:0];
    end else begin
      w_merge_data[{r_lane[1], 4'b0000} +: 16] = r_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered datapath and d_mem drive
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_size    <= c_SIZE_BYTE;
      r_uns     <= 1'b0;
      r_lane    <= 2'b00;
      r_wdata   <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_rdata   <= '0;
      r_mem_adr <= '0;
      r_mem_din <= '0;
      r_mem_we  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              r_done <= 1'b1;
              r_err  <= 1'b1;
            end else begin
              r_size    <= size;
              r_uns     <= uns;
              r_lane    <= addr[1:0];
              r_wdata   <= wdata[15:0];
              r_mem_adr <= {addr[ADDR_WIDTH-1:2], 2'b00};
              if (we && (size == c_SIZE_WORD)) begin
                r_mem_din <= wdata;
                r_mem_we  <= 1'b1;
              end
            end
          end
        end
        LOAD: begin
          r_rdata <= w_load_data;
          r_done  <= 1'b1;
        end
        RMW_RD: begin
          r_mem_din <= w_merge_data;
          r_mem_we  <= 1'b1;
        end
        WRITE: begin
          // d_mem commits on the falling edge inside this cycle
          r_mem_we <= 1'b0;
          r_done   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit with a byte-level
//            reference memory and an in-order scoreboard of completions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_adr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic [31:0] mem_dout;

  logic [31:0] dmem [64];
  logic [7:0]  ref_b [256];
  logic [31:0] ref_rdata;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    int          nwe;
    int          acc;
    bit          b2b;
  } exp_t;

  exp_t sb[$];

  int n_checks;
  int n_fail;
  int cycle;
  int we_cnt;
  int prev_done;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .we       (we),
    .size     (size),
    .uns      (uns),
    .addr     (addr),
    .wdata    (wdata),
    .ready    (ready),
    .done     (done),
    .err      (err),
    .rdata    (rdata),
    .mem_adr  (mem_adr),
    .mem_din  (mem_din),
    .mem_we   (mem_we),
    .mem_dout (mem_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // d_mem: asynchronous read, write on the falling edge
  assign mem_dout = dmem[mem_adr[7:2]];
  always @(negedge clk) begin
    if (mem_we) dmem[mem_adr[7:2]] <= mem_din;
  end

  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    return {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
  endfunction

  // Completion monitor, sampled on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      we_cnt = 0;
    end else begin
      if (mem_we) we_cnt++;
      chk_value("err_without_done", 32'(err & ~done), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          chk_value("unexpected_done", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk_value({e.tag, "_err"},     32'(err), 32'(e.err));
          chk_value({e.tag, "_rdata"},   rdata, e.rdata);
          chk_value({e.tag, "_latency"}, 32'(cycle - e.acc), 32'(e.lat));
          chk_value({e.tag, "_mem_we"},  32'(we_cnt), 32'(e.nwe));
          chk_value({e.tag, "_ready"},   32'(ready), 32'd1);
          if (e.b2b) chk_value({e.tag, "_no_bubble"}, 32'(e.acc), 32'(prev_done));
          prev_done = cycle;
          we_cnt    = 0;
        end
      end else if (sb.size() != 0) begin
        chk_value("ready_while_busy", 32'(ready), 32'd0);
      end
    end
  end

  // Drive one request; returns on the falling edge after its accept edge with req still high
  task automatic issue(input string tag, input bit w, input logic [1:0] sz, input bit u,
                       input logic [31:0] a, input logic [31:0] d, input bit b2b);
    exp_t e;
    int   n = 0;
    int   ai;
    bit   legal;
    logic [7:0]  b;
    logic [15:0] h;
    ai    = int'(a[7:0]);
    legal = !((sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00));
    e.tag = tag;
    e.b2b = b2b;
    e.err = !legal;
    e.nwe = 0;
    if (!legal) begin
      e.lat = 1;
    end else if (!w) begin
      e.lat = 2;
      b = ref_b[ai];
      h = {ref_b[ai+1], ref_b[ai]};
      case (sz)
        2'b00:   ref_rdata = u ? {24'd0, b} : 32'($signed(b));
        2'b01:   ref_rdata = u ? {16'd0, h} : 32'($signed(h));
        default: ref_rdata = ref_word(ai);
      endcase
    end else begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      e.nwe = 1;
      for (int i = 0; i < (1 << sz); i++) ref_b[ai+i] = d[8*i +: 8];
    end
    e.rdata = ref_rdata;

    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = d;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ready) chk_value({tag, "_accept_timeout"}, 32'(n), 32'd0);
    e.acc = cycle;
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    req = 1'b0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_value("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic op(input string tag, input bit w, input logic [1:0] sz, input bit u,
                    input logic [31:0] a, input logic [31:0] d);
    issue(tag, w, sz, u, a, d, 1'b0);
    drain();
  endtask

  initial begin
    n_checks = 0; n_fail = 0; cycle = 0; we_cnt = 0; prev_done = -1;
    ref_rdata = 32'd0;
    rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'd0; wdata = 32'd0;
    for (int i = 0; i < 256; i++) ref_b[i] = 8'(i * 7 + 3);
    ref_b[32'h20] = 8'h44; ref_b[32'h21] = 8'h33; ref_b[32'h22] = 8'h22; ref_b[32'h23] = 8'h11;
    for (int w = 0; w < 64; w++) dmem[w] = ref_word(4 * w);

    // Power-up reset
    repeat (3) @(negedge clk);
    chk_value("rst_ready",   32'(ready),  32'd0);
    chk_value("rst_done",    32'(done),   32'd0);
    chk_value("rst_err",     32'(err),    32'd0);
    chk_value("rst_mem_we",  32'(mem_we), 32'd0);
    chk_value("rst_rdata",   rdata,       32'd0);
    chk_value("rst_mem_adr", mem_adr,     32'd0);
    chk_value("rst_mem_din", mem_din,     32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset during the read phase of a byte RMW
    req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h21; wdata = 32'h77;
    chk_value("pre_rmw_ready", 32'(ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_value("midrst_ready",  32'(ready),  32'd0);
      chk_value("midrst_mem_we", 32'(mem_we), 32'd0);
      chk_value("midrst_done",   32'(done),   32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk_value("postrst_ready", 32'(ready), 32'd1);
    chk_value("postrst_word",  dmem[8], 32'h11223344);

    // Word store then load
    op("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    op("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    chk_value("lw_10_value", rdata, 32'hDEADBEEF);

    // Byte RMW over a known word
    op("sw_base", 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344);
    op("sb_13",   1'b1, 2'b00, 1'b0, 32'h13, 32'h123456A5);
    chk_value("sb_13_word", dmem[4], 32'hA5223344);

    // Sub-word loads with both extensions
    op("lb_13",  1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
    chk_value("lb_13_value", rdata, 32'hFFFFFFA5);
    op("lbu_13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    chk_value("lbu_13_value", rdata, 32'h000000A5);
    op("lh_12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    chk_value("lh_12_value", rdata, 32'hFFFFA522);
    op("lhu_10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
    op("lb_11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
    op("sh_16",  1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF8001);
    op("lh_16",  1'b0, 2'b01, 1'b0, 32'h16, 32'h0);

    // Illegal accesses
    op("ill_lh_11", 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
    op("ill_sw_12", 1'b1, 2'b10, 1'b0, 32'h12, 32'h55555555);
    op("ill_size",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    chk_value("ill_word_kept", dmem[4], 32'hA5223344);

    // Back-to-back with req held high
    issue("b2b_sw", 1'b1, 2'b10, 1'b0, 32'h30, 32'hCAFEF00D, 1'b0);
    issue("b2b_lw", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1'b1);
    drain();
    chk_value("b2b_lw_value", rdata, 32'hCAFEF00D);
    issue("b2b_sh", 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF, 1'b0);
    issue("b2b_lb", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0, 1'b1);
    issue("b2b_ill", 1'b1, 2'b01, 1'b0, 32'h23, 32'h0, 1'b1);
    issue("b2b_lh", 1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1);
    drain();

    // Final memory image against the byte model
    repeat (2) @(negedge clk);
    for (int w = 0; w < 64; w++) chk_value($sformatf("mem_word_%0d", w), dmem[w], ref_word(4 * w));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
